// File: rtl/mult_isolation_check_if.sv
// Operand/result bundle for mult_isolation_check: load strobes and operands in,
// both products, valid, sticky mismatch and compare counter out.
interface mult_isolation_check_if #(
   parameter int unsigned WS    = 16,
   parameter int unsigned CNT_W = 8
);
   logic              iex;
   logic [WS-1:0]     ix;
   logic              iey;
   logic [WS-1:0]     iy;
   logic [2*WS-1:0]   prod_main;
   logic [2*WS-1:0]   prod_iso;
   logic              out_valid;
   logic              mismatch;
   logic [CNT_W-1:0]  cmp_cnt;

   modport master (
      output iex, ix, iey, iy,
      input  prod_main, prod_iso, out_valid, mismatch, cmp_cnt
   );

   modport slave (
      input  iex, ix, iey, iy,
      output prod_main, prod_iso, out_valid, mismatch, cmp_cnt
   );
endinterface

// File: rtl/mult_isolation_check.sv
// Two equal-depth multiplier pipelines (free-running vs. dirty-bit isolated) with a
// built-in equivalence checker. Define MULT_CHECK_ASSERT_EN to compile in the assertion.
module mult_isolation_check #(
   parameter int unsigned WS     = 16,
   parameter int unsigned STAGES = 2,
   parameter int unsigned SIGNED = 0,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mult_isolation_check_if.slave bus
);
   localparam int unsigned PW = 2*WS;

   logic [WS-1:0]    na, nb, nc, nd;
   logic             x_q, y_q;
   logic             load_q;
   logic [PW-1:0]    main_prod, iso_prod;
   logic             mism_q;
   logic [CNT_W-1:0] cnt_q;

   function automatic logic [PW-1:0] ext(input logic [WS-1:0] v);
      ext = (SIGNED != 0) ? {{WS{v[WS-1]}}, v} : {{WS{1'b0}}, v};
   endfunction

   // Low PW bits of the extended product equal the signed product when SIGNED=1.
   assign main_prod = ext(na) * ext(nb);
   assign iso_prod  = ext(nc) * ext(nd);
   assign load_q    = x_q | y_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         na  <= '0;
         nb  <= '0;
         nc  <= '0;
         nd  <= '0;
         x_q <= 1'b1;
         y_q <= 1'b1;
      end else begin
         if (bus.iex) begin
            na <= bus.ix;
            nc <= bus.ix;
         end
         if (bus.iey) begin
            nb <= bus.iy;
            nd <= bus.iy;
         end
         x_q <= bus.iex;
         y_q <= bus.iey;
      end
   end

   for (genvar k = 1; k <= STAGES; k++) begin : g_st
      logic [PW-1:0] m_q, i_q, m_d, i_d;
      logic          d_q, adv;

      if (k == 1) begin : g_head
         assign m_d = main_prod;
         assign i_d = iso_prod;
         assign adv = load_q;
      end else begin : g_tail
         assign m_d = g_st[k-1].m_q;
         assign i_d = g_st[k-1].i_q;
         assign adv = g_st[k-1].d_q;
      end

      // Isolated stage only advances behind a dirty bit; main stage always loads.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            m_q <= '0;
            i_q <= '0;
            d_q <= 1'b0;
         end else begin
            m_q <= m_d;
            if (adv) i_q <= i_d;
            d_q <= adv;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mism_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         mism_q <= mism_q | (g_st[STAGES].m_q != g_st[STAGES].i_q);
         if (g_st[STAGES].d_q && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.prod_main = g_st[STAGES].m_q;
   assign bus.prod_iso  = g_st[STAGES].i_q;
   assign bus.out_valid = g_st[STAGES].d_q;
   assign bus.mismatch  = mism_q;
   assign bus.cmp_cnt   = cnt_q;

`ifdef MULT_CHECK_ASSERT_EN
   always_ff @(posedge clk) begin
      if (rst_n) begin
         a_equiv: assert (g_st[STAGES].m_q == g_st[STAGES].i_q);
      end
   end
`else
`endif

endmodule

// File: tb/tb_mult_isolation_check.sv
// Bench for mult_isolation_check: three configurations driven in lockstep and checked
// every cycle against an operand-history reference model plus directed vectors.
module tb_mult_isolation_check;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mult_isolation_check_if #(.WS(16), .CNT_W(8)) bus_a ();
   mult_isolation_check_if #(.WS(8),  .CNT_W(2)) bus_b ();
   mult_isolation_check_if #(.WS(8),  .CNT_W(8)) bus_c ();

   mult_isolation_check #(.WS(16), .STAGES(2), .SIGNED(0), .CNT_W(8))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   mult_isolation_check #(.WS(8), .STAGES(3), .SIGNED(1), .CNT_W(2))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
   mult_isolation_check #(.WS(8), .STAGES(1), .SIGNED(0), .CNT_W(8))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

   int checks = 0;
   int errors = 0;

   // Reference model: operand values and load flag after each edge since reset.
   int unsigned stg  [3] = '{2, 3, 1};
   int unsigned cmax [3] = '{255, 3, 255};
   logic [15:0] hx [0:4095];
   logic [15:0] hy [0:4095];
   bit          hl [0:4095];
   int          ne;
   int unsigned exp_cnt [3];

   function automatic longint unsigned mul(input int i, input logic [15:0] x, input logic [15:0] y);
      longint sx, sy;
      case (i)
         0:       return longint'(x) * longint'(y);
         1: begin
            sx = longint'($signed(x[7:0]));
            sy = longint'($signed(y[7:0]));
            return (sx * sy) & 64'hFFFF;
         end
         default: return longint'(x[7:0]) * longint'(y[7:0]);
      endcase
   endfunction

   function automatic longint unsigned exp_prod(input int i);
      int k = ne - int'(stg[i]);
      if (k < 0) return 0;
      return mul(i, hx[k], hy[k]);
   endfunction

   function automatic bit exp_valid(input int i);
      int k = ne - int'(stg[i]);
      if (k < 0) return 1'b0;
      return hl[k];
   endfunction

   task automatic model_reset();
      ne    = 0;
      hx[0] = '0;
      hy[0] = '0;
      hl[0] = 1'b1;
      for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
   endtask

   task automatic model_edge(input bit iex, input logic [15:0] ix, input bit iey, input logic [15:0] iy);
      for (int i = 0; i < 3; i++)
         if (exp_valid(i) && exp_cnt[i] < cmax[i]) exp_cnt[i]++;
      ne++;
      if (ne > 4095) begin
         $display("FAIL model_depth: got %0d edges limit 4095", ne);
         $fatal(1);
      end
      hx[ne] = iex ? ix : hx[ne-1];
      hy[ne] = iey ? iy : hy[ne-1];
      hl[ne] = iex | iey;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_inst(input int i, input string tag, input logic [63:0] pm, input logic [63:0] pi,
                           input logic ov, input logic mm, input logic [63:0] cc);
      chk({tag, ".prod_main"}, pm, exp_prod(i));
      chk({tag, ".prod_iso"},  pi, exp_prod(i));
      chk({tag, ".out_valid"}, 64'(ov), 64'(exp_valid(i)));
      chk({tag, ".mismatch"},  64'(mm), 64'd0);
      chk({tag, ".cmp_cnt"},   cc, 64'(exp_cnt[i]));
   endtask

   task automatic check_all();
      chk_inst(0, "a", bus_a.prod_main, bus_a.prod_iso, bus_a.out_valid, bus_a.mismatch, bus_a.cmp_cnt);
      chk_inst(1, "b", bus_b.prod_main, bus_b.prod_iso, bus_b.out_valid, bus_b.mismatch, bus_b.cmp_cnt);
      chk_inst(2, "c", bus_c.prod_main, bus_c.prod_iso, bus_c.out_valid, bus_c.mismatch, bus_c.cmp_cnt);
   endtask

   task automatic drive(input bit iex, input logic [15:0] ix, input bit iey, input logic [15:0] iy);
      bus_a.iex = iex;  bus_a.ix = ix;       bus_a.iey = iey;  bus_a.iy = iy;
      bus_b.iex = iex;  bus_b.ix = ix[7:0];  bus_b.iey = iey;  bus_b.iy = iy[7:0];
      bus_c.iex = iex;  bus_c.ix = ix[7:0];  bus_c.iey = iey;  bus_c.iy = iy[7:0];
   endtask

   task automatic step(input bit iex, input logic [15:0] ix, input bit iey, input logic [15:0] iy);
      drive(iex, ix, iey, iy);
      @(posedge clk);
      model_edge(iex, ix, iey, iy);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) step(1'b0, 16'h0, 1'b0, 16'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 16'h0);
      #1;
      model_reset();
      check_all();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [31:0] ea;
      logic [15:0] eb;
      logic [15:0] ec;
   } vec_t;

   vec_t tv [5];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int vcnt;
      logic [31:0] seen [4];

      tv[0] = '{16'd3,    16'd5,    32'd15,         16'd15,    16'd15};
      tv[1] = '{16'h00FE, 16'h0007, 32'h0000_06F2,  16'hFFF2,  16'h06F2};
      tv[2] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001,  16'h0001,  16'hFE01};
      tv[3] = '{16'h0080, 16'h0080, 32'h0000_4000,  16'h4000,  16'h4000};
      tv[4] = '{16'h1234, 16'h0010, 32'h0001_2340,  16'h0340,  16'h0340};

      rst_n = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 16'h0);
      #12;

      // Reset with no loads: a single out_valid pulse from the reset-time dirty bits.
      do_reset();
      vcnt = 0;
      for (int j = 0; j < 5; j++) begin
         step(1'b0, 16'h0, 1'b0, 16'h0);
         if (bus_a.out_valid) vcnt++;
      end
      chk("idle_valid_pulses_a", 64'(vcnt), 64'd1);

      // Directed product table, sampled at each configuration's latency.
      for (int t = 0; t < 5; t++) begin
         step(1'b1, tv[t].x, 1'b1, tv[t].y);
         for (int j = 1; j <= 3; j++) begin
            step(1'b0, 16'h0, 1'b0, 16'h0);
            if (j == 1) chk("tv.c_prod", 64'(bus_c.prod_main), 64'(tv[t].ec));
            if (j == 2) chk("tv.a_prod", 64'(bus_a.prod_iso),  64'(tv[t].ea));
            if (j == 3) chk("tv.b_prod", 64'(bus_b.prod_iso),  64'(tv[t].eb));
         end
      end

      // Back-to-back squares on the STAGES=2 instance.
      vcnt = 0;
      for (int n = 1; n <= 4; n++) begin
         step(1'b1, 16'(n), 1'b1, 16'(n));
         if (bus_a.out_valid && vcnt < 4) begin seen[vcnt] = bus_a.prod_main; vcnt++; end
      end
      for (int j = 0; j < 3; j++) begin
         step(1'b0, 16'h0, 1'b0, 16'h0);
         if (bus_a.out_valid && vcnt < 4) begin seen[vcnt] = bus_a.prod_main; vcnt++; end
      end
      chk("b2b_valid_count", 64'(vcnt), 64'd4);
      for (int n = 0; n < vcnt; n++) chk("b2b_square", 64'(seen[n]), 64'((n+1)*(n+1)));

      // Only x reloaded; y operand retained from an earlier load.
      step(1'b0, 16'h0, 1'b1, 16'd2);
      idle(3);
      step(1'b1, 16'd9, 1'b0, 16'h00AA);
      idle(5);
      chk("xonly_main_a", 64'(bus_a.prod_main), 64'd18);
      chk("xonly_iso_a",  64'(bus_a.prod_iso),  64'd18);
      chk("xonly_iso_b",  64'(bus_b.prod_iso),  64'd18);

      // Reset asserted between edges with products in flight.
      step(1'b1, 16'd7, 1'b1, 16'd7);
      step(1'b1, 16'd8, 1'b1, 16'd8);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("midrst_prod_a", 64'(bus_a.prod_main), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
      for (int n = 0; n < 5; n++) step(1'b1, 16'(n + 1), 1'b1, 16'd2);
      idle(4);
      chk("sat_cnt_b", 64'(bus_b.cmp_cnt), 64'd3);

      // Random traffic with occasional resets.
      do_reset();
      for (int r = 0; r < 300; r++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         step(1'($urandom_range(0, 1)), 16'($urandom()), 1'($urandom_range(0, 1)), 16'($urandom()));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mult_isolation_check.md
Name: mult_isolation_check

Overview:
- Parametrised successor to the two-path multiplier equivalence benchmark.
- Operands feed two multiplier pipelines of equal depth:
  - the main path recomputes every cycle;
  - the isolated path advances a stage only when a per-stage dirty bit marks a new operand load (operand isolation / clock-gating style).
- A built-in checker compares both outputs, flags any divergence (sticky) and counts compared results. Used as a model-checking target and as a reusable self-checking multiplier.

Parameters:
- WS, 16, operand width in bits; product width is 2*WS.
- STAGES, 2, product pipeline depth (>=1); STAGES=1 gives the legacy single-register behaviour.
- SIGNED, 0, 0 = unsigned multiply, 1 = two's-complement signed multiply.
- CNT_W, 8, width of the compare counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- iex  input  1  load strobe for operand x.
- ix  input  WS  operand x data.
- iey  input  1  load strobe for operand y.
- iy  input  WS  operand y data.
- prod_main  output  2*WS  final stage of the always-computing path.
- prod_iso  output  2*WS  final stage of the isolated path.
- out_valid  output  1  final stage holds a result tied to a load.
- mismatch  output  1  sticky; prod_main != prod_iso was seen at any edge since reset.
- cmp_cnt  output  CNT_W  number of out_valid cycles, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - operand registers na, nb, nc, nd = 0;
  - all pipeline stages of both paths = 0;
  - x_q = y_q = 1 (forces first computation), then dirty[1..STAGES] = 0;
  - prod_main = prod_iso = 0, out_valid = 0, mismatch = 0, cmp_cnt = 0.
- Operand load, each edge:
  - iex=1: na <= ix and nc <= ix;
  - iey=1: nb <= iy and nd <= iy;
  - x_q <= iex, y_q <= iey.
  - Simultaneous iex and iey load both operand pairs in the same cycle.
- Main path:
  - stage1 <= na*nb every edge;
  - stage k <= stage k-1 every edge, for k = 2..STAGES;
  - prod_main = stage STAGES.
- Isolated path:
  - dirty[1] <= x_q|y_q; dirty[k] <= dirty[k-1];
  - iso stage1 <= nc*nd only when x_q|y_q;
  - iso stage k <= iso stage k-1 only when dirty[k-1];
  - otherwise hold; prod_iso = iso stage STAGES.
- Latency: an operand loaded at edge E0 appears on both outputs after edge E0+STAGES.
- out_valid = dirty[STAGES].
- Arithmetic:
  - full 2*WS-bit product, no truncation;
  - SIGNED=1 sign-extends both operands to 2*WS bits before multiplying;
  - the same signedness applies to both paths.
- Checker:
  - mismatch <= mismatch | (prod_main != prod_iso), evaluated every edge, not only on valid;
  - cleared only by reset.
- cmp_cnt increments on each edge where out_valid=1; it holds at 2^CNT_W-1 and never wraps.
- Invariant: prod_main == prod_iso at all times; mismatch stays 0 in every correct build.
- Reset mid-operation: pipelines are flushed to 0 immediately and in-flight products are discarded; the first edge after release recomputes 0*0.

Optional Feature:
- Macro: MULT_CHECK_ASSERT_EN.
- Defined: an immediate assertion "prod_main == prod_iso", gated by rst_n, is compiled in, as the property the model checker proves.
- Undefined: no assertion is emitted; the mismatch and cmp_cnt outputs are unchanged and remain the only observable check.

Test Plan:
- Reset with STAGES=2, no loads → all outputs 0; out_valid pulses once at edge 2 after release (dirty from reset); mismatch=0.
- STAGES=3, WS=16, single cycle iex=1 ix=3, iey=1 iy=5 → prod_main = prod_iso = 15 exactly 3 edges later; out_valid high for 1 cycle; cmp_cnt +1.
- SIGNED=1, WS=8, ix=0xFE (-2), iy=0x07 → both products 0xFFF2 (-14); SIGNED=0 with the same inputs → 0x06F2.
- Back-to-back loads on 4 consecutive cycles (1×1, 2×2, 3×3, 4×4) → outputs 1, 4, 9, 16 on consecutive cycles; out_valid high 4 cycles; cmp_cnt=4.
- Only iex pulsed (ix=9) with nb previously 2 → 18 after STAGES edges; iso path holds 18 afterwards while main recomputes 18; no mismatch.
- rst_n asserted mid-pipeline, then CNT_W=2 with 5 loads → outputs 0 immediately; cmp_cnt saturates at 3; mismatch stays 0 throughout.
